// File: rtl/vga_rect_fill_if.sv
// Rectangle-fill command channel plus the shared pixel write port.
// The master side issues commands and may borrow the port; the slave side is the engine.
interface vga_rect_fill_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [8:0]            cmd_x0;
  logic [8:0]            cmd_y0;
  logic [9:0]            cmd_w;
  logic [9:0]            cmd_h;
  logic [DATA_WIDTH-1:0] cmd_color;
  logic                  fb_hold;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_hold,
    input  cmd_ready, busy, done, write_addr, write_data, write_enable
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_hold,
    output cmd_ready, busy, done, write_addr, write_data, write_enable
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Clipped rectangle fill engine: one pixel write per clock into the 400x300 framebuffer,
// raster order, with a same-cycle hold so other writers can share the port.
module vga_rect_fill #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int STRIDE_SHIFT = 9,
  parameter int FB_W         = 400,
  parameter int FB_H         = 300
) (
  input  logic            clk50M,
  input  logic            rst_n,
  vga_rect_fill_if.slave  bus
);

  localparam logic [10:0] FB_W11 = 11'(FB_W);
  localparam logic [10:0] FB_H11 = 11'(FB_H);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t state, state_nxt;

  // Stage p0: latched command; stage p1: clipped end coordinates.
  logic [8:0]            x0_p0, y0_p0;
  logic [9:0]            w_p0, h_p0;
  logic [DATA_WIDTH-1:0] color_p0;
  logic [10:0]           x_end_p1, y_end_p1;
  logic [8:0]            x, y;

  logic load_cmd, setup, adv, empty, last_x, last_y;
  logic [10:0] x_sum, y_sum;

  function automatic logic [10:0] clip_end(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign x_sum  = {2'b00, x0_p0} + {1'b0, w_p0};
  assign y_sum  = {2'b00, y0_p0} + {1'b0, h_p0};
  assign empty  = (w_p0 == 10'd0) || (h_p0 == 10'd0) ||
                  ({2'b00, x0_p0} >= FB_W11) || ({2'b00, y0_p0} >= FB_H11);
  assign last_x = ({2'b00, x} == (x_end_p1 - 11'd1));
  assign last_y = ({2'b00, y} == (y_end_p1 - 11'd1));

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    setup     = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          load_cmd  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        setup     = 1'b1;
        state_nxt = empty ? DONE : FILL;
      end
      FILL: begin
        if (!bus.fb_hold) begin
          adv = 1'b1;
          if (last_x && last_y) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers carry no reset; every output is gated by the FSM state.
  always_ff @(posedge clk50M) begin
    if (load_cmd) begin
      x0_p0    <= bus.cmd_x0;
      y0_p0    <= bus.cmd_y0;
      w_p0     <= bus.cmd_w;
      h_p0     <= bus.cmd_h;
      color_p0 <= bus.cmd_color;
    end
    if (setup) begin
      x_end_p1 <= clip_end(x_sum, FB_W11);
      y_end_p1 <= clip_end(y_sum, FB_H11);
      x        <= x0_p0;
      y        <= y0_p0;
    end else if (adv) begin
      if (last_x) begin
        x <= x0_p0;
        y <= y + 9'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.write_enable = (state == FILL) && !bus.fb_hold;
  assign bus.write_addr   = (state == FILL)
                            ? (ADDR_WIDTH'(y) << STRIDE_SHIFT) + ADDR_WIDTH'(x)
                            : '0;
  assign bus.write_data   = (state == FILL) ? color_p0 : '0;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: hand-computed write addresses, write cycles and done timing.
module tb_vga_rect_fill;

  logic clk50M;
  logic rst_n;

  vga_rect_fill_if #(.ADDR_WIDTH(18), .DATA_WIDTH(8)) bus ();

  vga_rect_fill dut (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  initial clk50M = 1'b0;
  always #5 clk50M = ~clk50M;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int x0, input int y0, input int w, input int h, input int col);
    bus.cmd_x0    = 9'(x0);
    bus.cmd_y0    = 9'(y0);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 10'(h);
    bus.cmd_color = 8'(col);
  endtask

  // Entered and left just after a posedge. Cycle 0 ends on the accept edge.
  task automatic do_cmd(input string name, input int x0, input int y0, input int w, input int h,
                        input int col, input int hold_from, input int hold_to, input int exp_done);
    int exp_cyc[$];
    int cyc;
    int wi;
    bit seen;
    cyc = 2;
    for (int i = 0; i < exp_addr.size(); i++) begin
      while (cyc >= hold_from && cyc <= hold_to) cyc++;
      exp_cyc.push_back(cyc);
      cyc++;
    end
    chk({name, "_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    set_cmd(x0, y0, w, h, col);
    bus.cmd_valid = 1'b1;
    @(posedge clk50M); #1;
    bus.cmd_valid = 1'b0;
    wi   = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      bus.fb_hold = (c >= hold_from && c <= hold_to);
      @(negedge clk50M);
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.fb_hold) chk({name, "_we_hold"}, 32'(bus.write_enable), 32'd0);
      if (bus.write_enable) begin
        if (wi < exp_addr.size()) begin
          chk({name, "_addr"}, 32'(bus.write_addr), exp_addr[wi]);
          chk({name, "_wcyc"}, 32'(c), 32'(exp_cyc[wi]));
          chk({name, "_data"}, 32'(bus.write_data), 32'(col));
        end else begin
          chk({name, "_extra_write"}, 32'(bus.write_addr), 32'hFFFF_FFFF);
        end
        wi++;
      end
      if (bus.done) begin
        chk({name, "_done_cyc"}, 32'(c), 32'(exp_done));
        seen = 1'b1;
        @(posedge clk50M); #1;
        break;
      end
      @(posedge clk50M); #1;
    end
    bus.fb_hold = 1'b0;
    chk({name, "_n_writes"}, 32'(wi), 32'(exp_addr.size()));
    if (!seen) chk({name, "_done_seen"}, 32'd0, 32'd1);
    @(negedge clk50M);
    chk({name, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, "_done_after"}, 32'(bus.done), 32'd0);
    @(posedge clk50M); #1;
    exp_addr.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.fb_hold   = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    #2;
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_we",    32'(bus.write_enable), 32'd0);
    chk("rst_addr",  32'(bus.write_addr), 32'd0);
    chk("rst_data",  32'(bus.write_data), 32'd0);
    @(posedge clk50M); @(posedge clk50M); #1;
    rst_n = 1'b1;
    @(posedge clk50M); #1;

    exp_addr.push_back(32'h00000);
    do_cmd("single", 0, 0, 1, 1, 8'hE3, 0, -1, 3);

    exp_addr = '{32'h0040A, 32'h0040B, 32'h0040C, 32'h0060A, 32'h0060B, 32'h0060C};
    do_cmd("small", 10, 2, 3, 2, 8'h1C, 0, -1, 8);

    exp_addr = '{32'h2578E, 32'h2578F};
    do_cmd("corner", 398, 299, 5, 5, 8'h03, 0, -1, 4);

    do_cmd("empty_w0", 20, 20, 0, 4, 8'hFF, 0, -1, 2);
    do_cmd("empty_x400", 400, 5, 4, 4, 8'hFF, 0, -1, 2);
    do_cmd("empty_y300", 5, 300, 4, 4, 8'hFF, 0, -1, 2);

    exp_addr = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    do_cmd("hold", 0, 0, 8, 1, 8'h92, 4, 6, 13);

    // cmd_valid stays high across an empty command; the second accept waits for IDLE.
    set_cmd(0, 0, 0, 1, 8'h11);
    bus.cmd_valid = 1'b1;
    @(posedge clk50M); #1;
    @(negedge clk50M); chk("vh_c1_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk50M); #1;
    @(negedge clk50M); chk("vh_c2_done", 32'(bus.done), 32'd1);
    chk("vh_c2_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk50M); #1;
    @(negedge clk50M); chk("vh_c3_ready", 32'(bus.cmd_ready), 32'd1);
    chk("vh_c3_done", 32'(bus.done), 32'd0);
    @(posedge clk50M); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk50M); chk("vh_c4_busy", 32'(bus.busy), 32'd1);
    @(posedge clk50M); #1;
    @(negedge clk50M); chk("vh_c5_done", 32'(bus.done), 32'd1);
    @(posedge clk50M); #1;
    @(negedge clk50M); chk("vh_c6_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk50M); #1;

    // Reset during the third write of a 10x10 fill.
    set_cmd(0, 0, 10, 10, 8'h55);
    bus.cmd_valid = 1'b1;
    @(posedge clk50M); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk50M); #1; end
    chk("mr_pre_we",   32'(bus.write_enable), 32'd1);
    chk("mr_pre_addr", 32'(bus.write_addr), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_we",    32'(bus.write_enable), 32'd0);
    chk("mr_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mr_busy",  32'(bus.busy), 32'd0);
    @(posedge clk50M); @(posedge clk50M); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50M);
      chk("mr_post_done",  32'(bus.done), 32'd0);
      chk("mr_post_we",    32'(bus.write_enable), 32'd0);
      chk("mr_post_busy",  32'(bus.busy), 32'd0);
      chk("mr_post_ready", 32'(bus.cmd_ready), 32'd1);
    end
    @(posedge clk50M); #1;

    exp_addr = '{32'h00A05, 32'h00A06, 32'h00C05, 32'h00C06};
    do_cmd("after_rst", 5, 5, 2, 2, 8'hAA, 0, -1, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
